// File: rtl/sbox_layer_if.sv
// Requester and result handshake bundle for the shared-S-box substitution layer.
// The master side is the requesters plus the result consumer; the slave side is the controller.
interface sbox_layer_if #(
  parameter int LANES = 6
);
  logic                 req0_valid;
  logic [6*LANES-1:0]   req0_data;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [6*LANES-1:0]   req1_data;
  logic                 req1_ready;
  logic                 res_valid;
  logic [6*LANES-1:0]   res_data;
  logic                 res_id;
  logic                 res_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/sbox_layer_ctrl.sv
// Two-requester front end that substitutes a word one 6-bit lane per cycle through a single
// shared external S-box, with round-robin arbitration between the requesters.
module sbox_layer_ctrl #(
  parameter int LANES = 6
) (
  input  logic             clk,
  input  logic             rst,
  sbox_layer_if.slave      bus,
  output logic [5:0]       sb_x,
  input  logic [5:0]       sb_y,
  output logic             busy
);

  localparam int W  = 6 * LANES;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            prio_q, prio_d;
  logic            grant1;
  logic            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant1 = bus.req1_valid && (!bus.req0_valid || prio_q);
    accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    prio_d  = prio_q;
    sb_x    = 6'd0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = grant1 ? bus.req1_data : bus.req0_data;
          id_d    = grant1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < LANES; i++) begin
          if (cnt_q == CW'(i)) begin
            sb_x             = work_q[6*i +: 6];
            work_d[6*i +: 6] = sb_y;
          end
        end
        if (cnt_q == CW'(LANES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Handing the turn to the other requester keeps a busy pair alternating.
        if (bus.res_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = accept && !grant1;
    bus.req1_ready = accept && grant1;
    bus.res_valid  = (state_q == DONE);
    bus.res_data   = work_q;
    bus.res_id     = id_q;
    busy           = (state_q != IDLE);
  end

endmodule

// File: doc/sbox_layer_ctrl.md
SBOX_LAYER_CTRL -- requirements
Module: sbox_layer_ctrl

Interface
REQ-001 Parameter: LANES, 6, number of 6-bit lanes per word; data width is 6*LANES.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has a word to substitute.
REQ-005 Port: req0_data  input  6*LANES  requester 0 word; lane i is bits 6i+5:6i.
REQ-006 Port: req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-007 Port: req1_valid, req1_data, req1_ready  input/input/output  1/6*LANES/1  requester 1, same semantics as requester 0.
REQ-008 Port: sb_x  output  6  operand to the shared external 6-bit S-box.
REQ-009 Port: sb_y  input  6  S-box result, combinational from sb_x in the same cycle.
REQ-010 Port: res_valid  output  1  substituted word available.
REQ-011 Port: res_data  output  6*LANES  substituted word.
REQ-012 Port: res_id  output  1  index of the requester that submitted the word.
REQ-013 Port: res_ready  input  1  consumer accepts the result.
REQ-014 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE: exactly one reqN_ready SHALL be high, chosen from the valid requesters; both ready SHALL be low if no request is valid; both ready SHALL be low in RUN and DONE.
REQ-017 Arbitration: if both requesters are valid, grant the one named by the priority pointer; if only one is valid, grant it regardless of the pointer.
REQ-018 Acceptance (valid && ready at an edge) SHALL capture the data into the working register, the id into res_id, clear the lane counter to 0, and enter RUN.
REQ-019 RUN: sb_x SHALL equal working-register lane[cnt]; at each edge, sb_y SHALL be written back into lane[cnt] and cnt SHALL increment.
REQ-020 RUN SHALL last exactly LANES cycles; the edge that processes lane LANES-1 SHALL enter DONE.
REQ-021 Latency: res_valid SHALL rise exactly LANES cycles after the accepting edge (6 cycles at the default).
REQ-022 DONE: res_valid = 1; res_data and res_id SHALL be held stable while res_ready is low.
REQ-023 DONE with res_ready high at an edge SHALL return to IDLE and set the priority pointer to the requester not equal to res_id.
REQ-024 No new request SHALL be accepted in the cycle that the result is taken; minimum issue interval is LANES+2 cycles.
REQ-025 sb_x SHALL be 0 in IDLE and DONE.
REQ-026 res_valid SHALL be 0 outside DONE; res_data SHALL show the working register at all times.
REQ-027 Changes on reqN_valid/reqN_data outside the accepting edge SHALL NOT affect in-flight work.
REQ-028 Lane processing order SHALL be lane 0 first, ascending.

Reset
REQ-029 While rst is high: state = IDLE, working register = 0, cnt = 0, res_id = 0, priority pointer = 0 (requester 0 favoured).
REQ-030 Reset outputs: res_valid = 0, res_data = 0, res_id = 0, busy = 0, sb_x = 0; reqN_ready follows REQ-016 in IDLE.
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL drop the in-flight word with no res_valid pulse; the first post-reset accept behaves as after power-up.

Verification (bench S-box stub: sb_y = sb_x ^ 6'h3F)
REQ-032 Single request: req0 0x000000000 with res_ready=1 -> res_valid 6 cycles after accept, res_data 0xFFFFFFFFF, res_id 0, busy high 7 cycles.
REQ-033 Simultaneous valid after reset: both requesters valid with 0x123456789 / 0xABCDEF012 -> req0 served first (res_data 0xEDCBA9876); req1 served next (res_data 0x543210FED, res_id 1).
REQ-034 Fairness: both valid continuously for 4 transactions -> res_id sequence 0,1,0,1.
REQ-035 Backpressure: res_ready low for 5 cycles in DONE -> res_valid, res_data, res_id stable; no reqN_ready during the stall; release -> IDLE next cycle.
REQ-036 Reset at RUN cycle 3 -> outputs return to reset values immediately; no res_valid; a subsequent req1 0xFFFFFFFFF -> res_data 0x000000000.
REQ-037 Lane order check: req0 0x000000001 -> sb_x sequence 0x01,0x00,0x00,0x00,0x00,0x00 over the six RUN cycles.
